// File: rtl/dispatch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_stage
//  Description : Single-entry registered dispatch buffer between rename and
//                the reservation stations / LSQ. Held operands snoop the CDB.
//                Optional DISPATCH_STATS_EN adds stall and dispatch counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module dispatch_stage #(
    parameter int ROBsize = 8,
    parameter int TAG_W   = $clog2(ROBsize + 1),
    parameter int DATA_W  = 64,
    parameter int NUM_RS  = 4,
    parameter int FU_W    = $clog2(NUM_RS),
    parameter int CMD_W   = 10
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [TAG_W-1:0]  src1_tag_i,
    input  logic [TAG_W-1:0]  src2_tag_i,
    input  logic [DATA_W-1:0] src1_val_i,
    input  logic [DATA_W-1:0] src2_val_i,
    input  logic [TAG_W-1:0]  dst_tag_i,
    input  logic [FU_W-1:0]   fu_sel_i,
    input  logic [CMD_W-1:0]  cmd_i,
    input  logic              is_mem_i,
    input  logic              is_store_i,
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_val_i,
    input  logic [NUM_RS-1:0] rs_full_i,
    input  logic              lsq_full_i,
    output logic [NUM_RS-1:0] rs_we_o,
    output logic [TAG_W-1:0]  rs_tag1_o,
    output logic [TAG_W-1:0]  rs_tag2_o,
    output logic [DATA_W-1:0] rs_val1_o,
    output logic [DATA_W-1:0] rs_val2_o,
    output logic [TAG_W-1:0]  rs_dst_o,
    output logic [CMD_W-1:0]  rs_cmd_o,
    output logic              lsq_new_o,
    output logic              lsq_store_o,
    output logic              illegal_o
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       dispatched_o
`endif
);

    localparam logic [FU_W:0] c_NUM_RS = (FU_W + 1)'(NUM_RS);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [TAG_W-1:0]    tag1_q, tag1_d, tag2_q, tag2_d, dst_q, dst_d;
    logic [DATA_W-1:0]   val1_q, val1_d, val2_q, val2_d;
    logic [FU_W-1:0]     fu_q, fu_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic                mem_q, mem_d, store_q, store_d, illegal_q, illegal_d;

    logic [NUM_RS-1:0]   w_sel;
    logic                w_tgt_full, w_fire, w_capture, w_legal;
    logic                w_byp1, w_byp2, w_fwd1, w_fwd2;

    assign w_sel      = NUM_RS'(1) << fu_q;
    assign w_tgt_full = |(rs_full_i & w_sel);
    assign w_fire     = (state_q == HELD) && !w_tgt_full && !(mem_q && lsq_full_i) && !flush_i;
    assign in_ready_o = (state_q == EMPTY) || w_fire;
    assign w_capture  = in_valid_i && in_ready_o && !flush_i;
    assign w_legal    = {1'b0, fu_sel_i} < c_NUM_RS;

    // Same-cycle CDB bypass on the held operands; tag 0 never matches.
    assign w_byp1 = cdb_valid_i && (tag1_q != '0) && (tag1_q == cdb_tag_i);
    assign w_byp2 = cdb_valid_i && (tag2_q != '0) && (tag2_q == cdb_tag_i);
    assign w_fwd1 = cdb_valid_i && (src1_tag_i != '0) && (src1_tag_i == cdb_tag_i);
    assign w_fwd2 = cdb_valid_i && (src2_tag_i != '0) && (src2_tag_i == cdb_tag_i);

    assign rs_we_o     = w_fire ? w_sel : '0;
    assign rs_tag1_o   = w_byp1 ? '0 : tag1_q;
    assign rs_tag2_o   = w_byp2 ? '0 : tag2_q;
    assign rs_val1_o   = w_byp1 ? cdb_val_i : val1_q;
    assign rs_val2_o   = w_byp2 ? cdb_val_i : val2_q;
    assign rs_dst_o    = dst_q;
    assign rs_cmd_o    = cmd_q;
    assign lsq_new_o   = w_fire && mem_q;
    assign lsq_store_o = store_q;
    assign illegal_o   = illegal_q;

    always_comb begin
        state_d   = state_q;
        tag1_d    = tag1_q;
        tag2_d    = tag2_q;
        val1_d    = val1_q;
        val2_d    = val2_q;
        dst_d     = dst_q;
        fu_d      = fu_q;
        cmd_d     = cmd_q;
        mem_d     = mem_q;
        store_d   = store_q;
        illegal_d = w_capture && !w_legal;

        if (w_capture && w_legal) begin
            tag1_d  = w_fwd1 ? '0 : src1_tag_i;
            tag2_d  = w_fwd2 ? '0 : src2_tag_i;
            val1_d  = w_fwd1 ? cdb_val_i : src1_val_i;
            val2_d  = w_fwd2 ? cdb_val_i : src2_val_i;
            dst_d   = dst_tag_i;
            fu_d    = fu_sel_i;
            cmd_d   = cmd_i;
            mem_d   = is_mem_i;
            store_d = is_store_i;
        end else if (state_q == HELD) begin
            tag1_d = rs_tag1_o;
            tag2_d = rs_tag2_o;
            val1_d = rs_val1_o;
            val2_d = rs_val2_o;
        end

        if (flush_i) begin
            state_d = EMPTY;
        end else if (w_capture && w_legal) begin
            state_d = HELD;
        end else if (w_fire) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= EMPTY;
            tag1_q    <= '0;
            tag2_q    <= '0;
            val1_q    <= '0;
            val2_q    <= '0;
            dst_q     <= '0;
            fu_q      <= '0;
            cmd_q     <= '0;
            mem_q     <= 1'b0;
            store_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag1_q    <= tag1_d;
            tag2_q    <= tag2_d;
            val1_q    <= val1_d;
            val2_q    <= val2_d;
            dst_q     <= dst_d;
            fu_q      <= fu_d;
            cmd_q     <= cmd_d;
            mem_q     <= mem_d;
            store_q   <= store_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d, dispatched_q, dispatched_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        dispatched_d   = dispatched_q;
        if ((state_q == HELD) && !w_fire && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (w_fire && (dispatched_q != 32'hFFFF_FFFF)) begin
            dispatched_d = dispatched_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_cycles_q <= '0;
            dispatched_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            dispatched_q   <= dispatched_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign dispatched_o   = dispatched_q;
`endif

endmodule
`default_nettype wire

// File: doc/dispatch_stage.md
# dispatch_stage

Registered dispatch stage between rename and the reservation stations and LSQ, parametrised in reservation station count, data width and ROB depth. It holds one renamed instruction under a valid/ready handshake. While holding, its waiting source operands snoop the completion bus. It writes the instruction into the selected reservation station, and into the LSQ for memory operations, once the targets have room.

## Interface
- ROBsize, 8: ROB entries; tag 0 means "value ready", tags run 1..ROBsize.
- TAG_W, $clog2(ROBsize+1): ROB tag width.
- DATA_W, 64: operand data width.
- NUM_RS, 4: reservation station count (2..8).
- FU_W, $clog2(NUM_RS): width of the station selector.
- CMD_W, 10: command bundle width.

Ports:
- clk_i in 1: clock.
- reset_i in 1: asynchronous, active-low reset.
- flush_i in 1: discard the held entry.
- in_valid_i in 1: rename offers an instruction.
- in_ready_o out 1: stage accepts an instruction this cycle.
- src1_tag_i / src2_tag_i in TAG_W: producer tag; 0 means the value is ready.
- src1_val_i / src2_val_i in DATA_W: operand values, valid when the matching tag is 0.
- dst_tag_i in TAG_W: ROB tail allocated to this instruction.
- fu_sel_i in FU_W: target reservation station.
- cmd_i in CMD_W: command bundle.
- is_mem_i in 1: instruction also enters the LSQ.
- is_store_i in 1: the memory operation is a store.
- cdb_valid_i in 1: completion broadcast is valid.
- cdb_tag_i in TAG_W: completion tag.
- cdb_val_i in DATA_W: completion value.
- rs_full_i in NUM_RS: per-station full flag.
- lsq_full_i in 1: LSQ full.
- rs_we_o out NUM_RS: one-hot station write enable.
- rs_tag1_o / rs_tag2_o out TAG_W: operand tags sent to the station.
- rs_val1_o / rs_val2_o out DATA_W: operand values sent to the station.
- rs_dst_o out TAG_W: destination tag.
- rs_cmd_o out CMD_W: command bundle.
- lsq_new_o out 1: LSQ allocate.
- lsq_store_o out 1: 1 for a store, 0 for a load.
- illegal_o out 1: one-cycle pulse, fu_sel_i was at or above NUM_RS.

## Operation
- States: EMPTY and HELD, held in one register bit.
- in_ready_o = EMPTY or fire.
- Capture happens when in_valid_i, in_ready_o and not flush_i are all true.
  - If fu_sel_i is at or above NUM_RS, the instruction is dropped and illegal_o pulses next cycle.
  - Otherwise the stage moves to HELD.
- Capture-time forwarding applies to each source independently: if cdb_valid_i, the source tag is nonzero and the source tag equals cdb_tag_i, the stage stores cdb_val_i with tag 0.
- Holding snoop: in HELD, every cycle each operand with a nonzero tag equal to cdb_tag_i (with cdb_valid_i) takes cdb_val_i and its tag becomes 0.
- fire = HELD, not rs_full_i[fu] for the held fu, not (mem and lsq_full_i), and not flush_i.
- rs_we_o[fu] = fire, driven combinationally from the register. lsq_new_o = fire and mem. lsq_store_o = held store bit.
- rs_* data outputs reflect the held register at all times, meaningful only when the enable is high.
- The outputs fold in same-cycle CDB bypass, so a value completing in the fire cycle reaches the station with tag 0.
- Transitions:
  - EMPTY to HELD on a legal capture.
  - HELD to EMPTY on fire without a new capture.
  - HELD stays HELD on fire with a capture (back-to-back), or on a stall.
  - Any state goes to EMPTY on flush_i.
- flush_i wins over capture and fire: rs_we_o = 0, lsq_new_o = 0, nothing is captured. in_ready_o stays driven per the formula, but the upstream transfer is discarded.
- CDB traffic with tag 0 is ignored.

## Timing
- Reset (asynchronous assert, clock-synchronous release):
  - State is EMPTY and all registers are 0.
  - Outputs: in_ready_o = 1; rs_we_o, lsq_new_o, lsq_store_o and illegal_o are 0; data outputs are 0.
- Latency: capture at edge N, earliest rs_we_o in cycle N+1. Sustained throughput is 1 per cycle when no target is full.
- A stall holds the entry indefinitely while snooping continues. No combinational path runs from rs_full_i or lsq_full_i to the data outputs.
- Reset asserted mid-hold drops the entry immediately, with no write pulse.

## Configuration
- DISPATCH_STATS_EN defined: adds stall_cycles_o (out 32) and dispatched_o (out 32).
  - stall_cycles_o counts cycles in HELD without fire.
  - dispatched_o counts fires.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Not defined: the counter ports and logic are absent; all other behaviour is identical.

## Test plan
- After reset, offer src1 tag 0 / val 5, src2 tag 0 / val 7, fu 2, dst 3: in_ready_o = 1, and next cycle rs_we_o = 0100 with values 5/7, tags 0/0 and rs_dst_o = 3.
- Hold with rs_full_i[1] = 1 and src2 tag 4; pulse CDB tag 4 / val 0x99 during the stall, then clear the full flag: the station receives tag2 = 0 and val2 = 0x99, and in_ready_o stays 0 throughout the stall.
- Fire and CDB tag 6 in the same cycle as an operand waiting on tag 6: the write carries tag 0 with the CDB value.
- Store with lsq_full_i = 1 for 3 cycles: no rs_we_o and no lsq_new_o until the flag drops, then rs_we_o and lsq_new_o pulse together with lsq_store_o = 1.
- Back-to-back stream of 4 instructions with no targets full: 4 consecutive fires with in_ready_o held at 1. flush_i during a hold: no write, and the next cycle is EMPTY.
- With NUM_RS = 3, fu_sel_i = 3: illegal_o pulses and no write occurs. With DISPATCH_STATS_EN, a 5-cycle stall gives stall_cycles_o = 5.
